lc3_ea_ctrl: RTL and testbench

Effective-address sequencer for the LC-3 datapath. It accepts one instruction at a time and decodes the opcode to select the sign-extended immediate: SEXT5, SEXT6, SEXT9, SEXT11, or ZEXT8 for TRAP. It then adds the immediate to PC or BaseR and, for LDI/STI, performs the indirect memory read. The result goes to the memory/register stage over a valid/ready handshake, so the control FSM does not hand-sequence address generation.

---
 rtl/lc3_ea_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lc3_ea_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_ea_ctrl.sv
// LC-3 effective-address sequencer.
// Decodes IR, forms EA/immediate, optional indirect read.
module lc3_ea_ctrl (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] ir,
  input  logic [15:0] pc,
  input  logic [15:0] base,
  output logic        mem_rd_valid,
  output logic [15:0] mem_rd_addr,
  input  logic        mem_rd_ready,
  input  logic        mem_rsp_valid,
  input  logic [15:0] mem_rsp_data,
  output logic        ea_valid,
  input  logic        ea_ready,
  output logic [15:0] ea,
  output logic [2:0]  ea_sel,
  output logic        ea_indirect,
  output logic        ea_none
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_S5   = 3'd1;
  localparam logic [2:0] SEL_S6   = 3'd2;
  localparam logic [2:0] SEL_S9   = 3'd3;
  localparam logic [2:0] SEL_S11  = 3'd4;
  localparam logic [2:0] SEL_Z8   = 3'd5;
  localparam logic [2:0] SEL_BASE = 3'd6;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] base_q, base_d;
  logic [15:0] ea_q, ea_d;
  logic [2:0]  sel_q, sel_d;
  logic        ind_q, ind_d;
  logic        none_q, none_d;
  logic [15:0] addr_q, addr_d;

  logic [3:0]  op;
  logic [15:0] sext5, sext6, sext9, sext11, zext8;
  logic        is_pc9, is_ind, is_jsr, is_jsrr;
  logic        is_ldr, is_imm, is_trap;
  logic [15:0] calc_ea;
  logic [2:0]  calc_sel;
  logic        calc_none;

  // Immediate extraction and opcode class decode
  always_comb begin
    op     = ir_q[15:12];
    sext5  = {{11{ir_q[4]}}, ir_q[4:0]};
    sext6  = {{10{ir_q[5]}}, ir_q[5:0]};
    sext9  = {{7{ir_q[8]}}, ir_q[8:0]};
    sext11 = {{5{ir_q[10]}}, ir_q[10:0]};
    zext8  = {8'h00, ir_q[7:0]};
    is_pc9 = (op == 4'b0000) || (op == 4'b0010)
          || (op == 4'b0011) || (op == 4'b1110);
    is_ind = (op == 4'b1010) || (op == 4'b1011);
    is_jsr = (op == 4'b0100) && ir_q[11];
    is_jsrr = ((op == 4'b0100) && !ir_q[11])
           || (op == 4'b1100);
    is_ldr = (op == 4'b0110) || (op == 4'b0111);
    is_imm = ((op == 4'b0001) || (op == 4'b0101))
          && ir_q[5];
    is_trap = (op == 4'b1111);
  end

  // Select immediate source and form the 16-bit sum
  always_comb begin
    calc_ea   = 16'h0000;
    calc_sel  = SEL_NONE;
    calc_none = 1'b0;
    unique case (1'b1)
      is_pc9, is_ind: begin
        calc_ea  = pc_q + sext9;
        calc_sel = SEL_S9;
      end
      is_jsr: begin
        calc_ea  = pc_q + sext11;
        calc_sel = SEL_S11;
      end
      is_jsrr: begin
        calc_ea  = base_q;
        calc_sel = SEL_BASE;
      end
      is_ldr: begin
        calc_ea  = base_q + sext6;
        calc_sel = SEL_S6;
      end
      is_imm: begin
        calc_ea  = sext5;
        calc_sel = SEL_S5;
      end
      is_trap: begin
        calc_ea  = zext8;
        calc_sel = SEL_Z8;
      end
      default: begin
        calc_none = 1'b1;
      end
    endcase
  end

  // Next-state and result register updates
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    base_d  = base_q;
    ea_d    = ea_q;
    sel_d   = sel_q;
    ind_d   = ind_q;
    none_d  = none_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ir_d    = ir;
          pc_d    = pc;
          base_d  = base;
          state_d = CALC;
        end
      end
      CALC: begin
        ea_d   = calc_ea;
        sel_d  = calc_sel;
        none_d = calc_none;
        ind_d  = 1'b0;
        if (is_ind) begin
          addr_d  = calc_ea;
          state_d = MEM_REQ;
        end else begin
          state_d = RESP;
        end
      end
      MEM_REQ: begin
        if (mem_rd_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) begin
          ea_d    = mem_rsp_data;
          ind_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (ea_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      base_q  <= '0;
      ea_q    <= '0;
      sel_q   <= '0;
      ind_q   <= 1'b0;
      none_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      ea_q    <= ea_d;
      sel_q   <= sel_d;
      ind_q   <= ind_d;
      none_q  <= none_d;
      addr_q  <= addr_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign mem_rd_valid = (state_q == MEM_REQ);
  assign ea_valid     = (state_q == RESP);
  assign mem_rd_addr  = addr_q;
  assign ea           = ea_q;
  assign ea_sel       = sel_q;
  assign ea_indirect  = ind_q;
  assign ea_none      = none_q;

endmodule

// File: tb/tb_lc3_ea_ctrl.sv
// Bench for lc3_ea_ctrl: vector table driven,
// results checked through a scoreboard queue.
module tb_lc3_ea_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] ir = '0;
  logic [15:0] pc = '0;
  logic [15:0] base = '0;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = '0;
  logic        ea_valid;
  logic        ea_ready = 1'b0;
  logic [15:0] ea;
  logic [2:0]  ea_sel;
  logic        ea_indirect;
  logic        ea_none;

  lc3_ea_ctrl dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .ir(ir),
    .pc(pc),
    .base(base),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_ready(mem_rd_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .ea_valid(ea_valid),
    .ea_ready(ea_ready),
    .ea(ea),
    .ea_sel(ea_sel),
    .ea_indirect(ea_indirect),
    .ea_none(ea_none)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] base;
    logic [15:0] mdata;
    logic [15:0] addr;
    logic [15:0] ea;
    logic [2:0]  sel;
    logic        ind;
    logic        none;
    int          rdly;
    int          mdly;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [15:0] i_ir, input logic [15:0] i_pc,
    input logic [15:0] i_base, input logic [15:0] i_md,
    input logic [15:0] i_addr, input logic [15:0] i_ea,
    input logic [2:0] i_sel, input logic i_ind,
    input logic i_none, input int i_rdly, input int i_mdly);
    vec_t v;
    v.ir = i_ir; v.pc = i_pc; v.base = i_base;
    v.mdata = i_md; v.addr = i_addr; v.ea = i_ea;
    v.sel = i_sel; v.ind = i_ind; v.none = i_none;
    v.rdly = i_rdly; v.mdly = i_mdly;
    return v;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: compare at each accepted result transfer
  always @(negedge Clk) begin
    if (Reset_n && ea_valid && ea_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 16'h1, 16'h0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("ea", ea, e.ea);
        chk("ea_sel", {13'd0, ea_sel}, {13'd0, e.sel});
        chk("ea_ind", {15'd0, ea_indirect},
            {15'd0, e.ind});
        chk("ea_none", {15'd0, ea_none},
            {15'd0, e.none});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    req_valid = 1'b1;
    ir = v.ir; pc = v.pc; base = v.base;
    sb.push_back(v);
    step();
    req_valid = 1'b0;
    ir = 16'($urandom);
    pc = 16'($urandom);
    base = 16'($urandom);
    chk("calc_valid", {15'd0, ea_valid}, 16'd0);
    chk("calc_rdy", {15'd0, req_ready}, 16'd0);
    step();
    if (v.ind) begin
      chk("rd_valid", {15'd0, mem_rd_valid}, 16'd1);
      chk("rd_addr", mem_rd_addr, v.addr);
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 16'hDEAD;
      for (int i = 0; i < v.mdly; i++) begin
        step();
        chk("rd_hold", {15'd0, mem_rd_valid}, 16'd1);
        chk("rd_addr_hold", mem_rd_addr, v.addr);
      end
      mem_rsp_valid = 1'b0;
      mem_rd_ready = 1'b1;
      step();
      mem_rd_ready = 1'b0;
      chk("wait_rd", {15'd0, mem_rd_valid}, 16'd0);
      chk("wait_valid", {15'd0, ea_valid}, 16'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data = v.mdata;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data = '0;
    end
    chk("ea_valid_lat", {15'd0, ea_valid}, 16'd1);
    if (v.rdly > 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 16'h5A5A;
    end
    for (int i = 0; i < v.rdly; i++) begin
      step();
      chk("resp_hold_v", {15'd0, ea_valid}, 16'd1);
      chk("resp_hold_ea", ea, v.ea);
    end
    mem_rsp_valid = 1'b0;
    ea_ready = 1'b1;
    step();
    ea_ready = 1'b0;
    chk("back_idle", {15'd0, req_ready}, 16'd1);
    chk("valid_drop", {15'd0, ea_valid}, 16'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, {15'd0, req_ready}, 16'd1);
    chk({tag, "_eav"}, {15'd0, ea_valid}, 16'd0);
    chk({tag, "_rdv"}, {15'd0, mem_rd_valid}, 16'd0);
    chk({tag, "_addr"}, mem_rd_addr, 16'h0000);
    chk({tag, "_ea"}, ea, 16'h0000);
    chk({tag, "_sel"}, {13'd0, ea_sel}, 16'd0);
    chk({tag, "_ind"}, {15'd0, ea_indirect}, 16'd0);
    chk({tag, "_none"}, {15'd0, ea_none}, 16'd0);
  endtask

  initial begin
    vecs.push_back(mk(16'h6A7F, 16'h0000, 16'h3000,
      16'h0, 16'h0, 16'h2FFF, 3'd2, 0, 0, 5, 0));
    vecs.push_back(mk(16'h0FFF, 16'h0000, 16'h0000,
      16'h0, 16'h0, 16'hFFFF, 3'd3, 0, 0, 0, 0));
    vecs.push_back(mk(16'hA002, 16'h3001, 16'h0000,
      16'h4000, 16'h3003, 16'h4000, 3'd3, 1, 0, 1, 3));
    vecs.push_back(mk(16'h4C00, 16'h3000, 16'h0000,
      16'h0, 16'h0, 16'h2C00, 3'd4, 0, 0, 0, 0));
    vecs.push_back(mk(16'h4080, 16'h0000, 16'h1234,
      16'h0, 16'h0, 16'h1234, 3'd6, 0, 0, 2, 0));
    vecs.push_back(mk(16'h1030, 16'h0000, 16'h0000,
      16'h0, 16'h0, 16'hFFF0, 3'd1, 0, 0, 0, 0));
    vecs.push_back(mk(16'hF025, 16'h1111, 16'h2222,
      16'h0, 16'h0, 16'h0025, 3'd5, 0, 0, 0, 0));
    vecs.push_back(mk(16'h903F, 16'h1111, 16'h2222,
      16'h0, 16'h0, 16'h0000, 3'd0, 0, 1, 0, 0));
    vecs.push_back(mk(16'hE0FF, 16'h3000, 16'h0000,
      16'h0, 16'h0, 16'h30FF, 3'd3, 0, 0, 0, 0));
    vecs.push_back(mk(16'hB1FE, 16'h0001, 16'h0000,
      16'hBEEF, 16'hFFFF, 16'hBEEF, 3'd3, 1, 0, 0, 0));
    vecs.push_back(mk(16'hC1C0, 16'h0000, 16'hABCD,
      16'h0, 16'h0, 16'hABCD, 3'd6, 0, 0, 0, 0));
    vecs.push_back(mk(16'h5042, 16'h1234, 16'h4321,
      16'h0, 16'h0, 16'h0000, 3'd0, 0, 1, 0, 0));
    vecs.push_back(mk(16'h7041, 16'h0000, 16'hFFFF,
      16'h0, 16'h0, 16'h0000, 3'd2, 0, 0, 0, 0));
    vecs.push_back(mk(16'hD000, 16'h5555, 16'h6666,
      16'h0, 16'h0, 16'h0000, 3'd0, 0, 1, 0, 0));
    vecs.push_back(mk(16'h8000, 16'h5555, 16'h6666,
      16'h0, 16'h0, 16'h0000, 3'd0, 0, 1, 0, 0));

    #2;
    chk_reset_vals("rst0");
    step();
    Reset_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Reset while an indirect read is outstanding
    req_valid = 1'b1;
    ir = 16'hA002; pc = 16'h3001; base = 16'h0;
    step();
    req_valid = 1'b0;
    step();
    chk("ab_rd_addr", mem_rd_addr, 16'h3003);
    mem_rd_ready = 1'b1;
    step();
    mem_rd_ready = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    step();
    Reset_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 16'h7777;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    chk_reset_vals("stray");
    step();
    run_vec(mk(16'h6A7F, 16'h0000, 16'h3000,
      16'h0, 16'h0, 16'h2FFF, 3'd2, 0, 0, 0, 0));

    step();
    chk("sb_left", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule
